// File: rtl/uart_reg_arb_pkg.sv
// rtl/uart_reg_arb_pkg.sv - shared types, register offsets and address check for the UART register arbiter
package uart_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Word offsets of the UART0 registers inside the window.
  localparam logic [31:0] UART0_DR_OFS  = 32'h0;
  localparam logic [31:0] UART0_RSR_OFS = 32'h4;
  localparam logic [31:0] UART0_FR_OFS  = 32'h8;

  // Legal means word aligned and one of the first num_regs words at or above base.
  function automatic logic addr_legal(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] num_regs);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (off[1:0] == 2'b00) && ((off >> 2) < num_regs);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - round-robin one-hot grant with a rotating priority pointer
module uart_rr_arbiter
  import uart_reg_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr_q;
  logic [PW-1:0]  ptr_nxt;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_gnt;
  logic [PW-1:0]  rot_idx;
  logic [2*N-1:0] gnt_dbl;
  logic [PW:0]    sum;

  // Rotate requests so the pointer position is bit 0, pick the lowest, rotate back.
  always_comb begin
    rot_req = N'({req, req} >> ptr_q);
    rot_gnt = '0;
    rot_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        rot_gnt    = '0;
        rot_gnt[k] = 1'b1;
        rot_idx    = PW'(k);
      end
    end
    gnt_dbl = {{N{1'b0}}, rot_gnt} << ptr_q;
    grant   = enable ? (gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N]) : '0;
    // Pointer moves to one past the granted requester, modulo N.
    sum     = (PW+1)'(rot_idx) + (PW+1)'(ptr_q) + (PW+1)'(1);
    ptr_nxt = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
  end

  // Priority pointer: requester 0 first out of reset, advance on every accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/uart_reg_arbiter.sv
// rtl/uart_reg_arbiter.sv - shares the UART register bus between requesters, one command at a time
module uart_reg_arbiter
  import uart_reg_arb_pkg::*;
#(
  parameter int                    NUM_REQ    = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_C000,
  parameter int                    NUM_REGS   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            bus_addr,
  output logic                             bus_wr_en,
  output logic                             bus_valid,
  output logic [DATA_WIDTH-1:0]            bus_wdata,
  input  logic [DATA_WIDTH-1:0]            bus_rdata,
  output logic                             busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q, state_d;
  logic [OW-1:0]         owner_q, gnt_idx;
  logic                  wr_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, sel_wdata;
  logic                  sel_wr, legal, accept;

  uart_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .enable  (state_q == IDLE),
    .advance (accept),
    .grant   (req_ready)
  );

  assign accept = |req_ready;

  // Mux the granted requester's payload and classify its address.
  always_comb begin
    gnt_idx   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx   = OW'(i);
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    legal = addr_legal(64'(sel_addr), 64'(BASE_ADDR), 64'(NUM_REGS));
  end

  // Next state and all outputs; bus and response outputs are idle-zero by default.
  always_comb begin
    state_d   = state_q;
    bus_valid = 1'b0;
    bus_wr_en = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (accept) state_d = legal ? ISSUE : RESP;
      end
      ISSUE: begin
        bus_valid = 1'b1;
        bus_wr_en = wr_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        state_d   = wr_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Command latch on accept; read data is cleared there so writes and errors answer 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= gnt_idx;
        wr_q    <= sel_wr;
        err_q   <= !legal;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        rdata_q <= '0;
      end
      if (state_q == CAPTURE) rdata_q <= bus_rdata;
    end
  end

endmodule

// File: doc/uart_reg_arbiter.md
Name: uart_reg_arbiter

Overview:
- Shares the single UART register-bus slave (addr/wr_en/valid/wdata/rdata at 0x4000_C000..0x4000_C008) between NUM_REQ requesters, e.g. the CPU bridge and the boot-config sequencer.
- Accepts one command at a time, selected round-robin.
- Drives exactly one single-cycle bus strobe per command and returns a one-cycle response to the owning requester.
- Addresses outside the register window are rejected without any bus access.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width.
- BASE_ADDR, 32'h4000_C000, address of register 0.
- NUM_REGS, 3, number of legal word registers at BASE_ADDR + 4*k.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous active-low reset; sampled on posedge clk; 0 = reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same slicing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters.
- rsp_err  out  1  illegal-address flag, qualified by rsp_valid.
- bus_addr  out  ADDR_WIDTH  address to register block.
- bus_wr_en  out  1  bus write enable.
- bus_valid  out  1  bus access strobe.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_rdata  in  DATA_WIDTH  bus read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all outputs 0.
  - RR pointer set so requester 0 has highest priority.
  - Any in-flight command is dropped with no response.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the first requester with req_valid=1, searching upward from (last_grant+1) mod NUM_REQ.
  - On the edge with valid&ready: latch owner, wr, addr, wdata; last_grant <= owner.
  - Legal address -> ISSUE. Illegal address (not BASE_ADDR+4k with k<NUM_REGS, or not word-aligned) -> RESP with err.
- ISSUE, exactly 1 cycle:
  - bus_valid=1; bus_wr_en=latched wr; bus_addr and bus_wdata driven from the latched command.
  - Write -> RESP. Read -> CAPTURE.
- CAPTURE, 1 cycle:
  - bus outputs return to 0.
  - bus_rdata, which updates on the ISSUE edge, is registered at the end of this cycle.
  - Next state RESP.
- RESP, 1 cycle:
  - rsp_valid[owner]=1.
  - rsp_rdata = captured data for reads, 0 for writes and errors.
  - rsp_err=1 only on the illegal-address path.
  - Next state IDLE.
- Latency from accept edge T: write response in cycle T+2, read in T+3, error in T+1.
  - One command in flight at a time.
  - A new accept is possible in the cycle after RESP.
- bus_* outputs are 0 in all states except ISSUE. Exactly one bus_valid pulse per legal command.
- Requesters hold req_valid and payload stable until req_ready. Response has no back-pressure.
- req_ready is 0 outside IDLE. Requests arriving while busy wait.
- Simultaneous requests are round-robin: after granting i, i+1 has priority. No requester is starved for more than NUM_REQ-1 grants.
- req_valid dropping before ready: no grant, no state change.

Decomposition:
- Package uart_reg_arb_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, RESP).
  - UART0_DR/RSR/FR offset constants (0x0, 0x4, 0x8).
  - function addr_legal().
- Sub-module uart_rr_arbiter: parameter N; inputs req vector, enable, advance; outputs one-hot grant. Holds the RR pointer.
- FSM and datapath live in the top.

Test Plan:
- Single write: req 0 writes 0x4000_C004 = 0xDEAD_BEEF -> one bus_valid pulse with wr_en=1 at T+1; rsp_valid[0] at T+2; rsp_err=0.
- Read-back: req 1 reads 0x4000_C004 after the write above -> bus_valid with wr_en=0 at T+1; rsp_valid[1] at T+3 with rsp_rdata=0xDEAD_BEEF.
- Contention: req 0 and req 1 both valid continuously, four writes each -> grants alternate 0,1,0,1...; exactly 8 bus pulses; no grant while busy.
- Illegal address: req 0 reads 0x4000_C00C, then 0x4000_C002 -> each gives rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0; no bus_valid.
- Reset mid-op: rst=0 during CAPTURE -> next cycle all outputs 0, no rsp_valid. After release, req 1 and req 0 both valid -> req 0 granted first.
- Hold-off: req 1 asserts during req 0's RESP -> req_ready[1] only in the following IDLE cycle; payload is latched unchanged.
